// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 bus responder: FSM states,
// local address map, interrupt bit positions and the local address decoder.
package sm83_pkg;

    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCAL    = 2'd1,
        EXT_WAIT = 2'd2,
        RESP     = 2'd3
    } resp_state_e;

    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_STAT   = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_bit_e;

    typedef enum logic [2:0] {
        RGN_HRAM     = 3'd0,
        RGN_IF       = 3'd1,
        RGN_IE       = 3'd2,
        RGN_UNUSABLE = 3'd3,
        RGN_EXT      = 3'd4
    } region_e;

    localparam int IRQ_W      = 5;
    localparam int HRAM_DEPTH = 127;
    localparam int HRAM_AW    = 7;

    localparam addr_t HRAM_BASE     = 16'hFF80;
    localparam addr_t HRAM_TOP      = 16'hFFFE;
    localparam addr_t IF_ADDR       = 16'hFF0F;
    localparam addr_t IE_ADDR       = 16'hFFFF;
    localparam addr_t UNUSABLE_BASE = 16'hFEA0;
    localparam addr_t UNUSABLE_TOP  = 16'hFEFF;

    // Value returned for writes, unusable reads and abandoned external reads.
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    function automatic region_e decode_addr(input addr_t addr);
        region_e rgn;
        if (addr == IE_ADDR) begin
            rgn = RGN_IE;
        end else if (addr == IF_ADDR) begin
            rgn = RGN_IF;
        end else if (addr >= HRAM_BASE && addr <= HRAM_TOP) begin
            rgn = RGN_HRAM;
        end else if (addr >= UNUSABLE_BASE && addr <= UNUSABLE_TOP) begin
            rgn = RGN_UNUSABLE;
        end else begin
            rgn = RGN_EXT;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/sm83_bus_resp_if.sv
// CPU request/response handshake plus the external access port of the responder.
// slave = the responder, master = the CPU side together with the external memory.
interface sm83_bus_resp_if;
    import sm83_pkg::*;

    logic       cpu_req_valid;
    logic       cpu_req_ready;
    logic       cpu_req_we;
    addr_t      cpu_req_addr;
    logic [7:0] cpu_req_wdata;
    logic       cpu_rsp_valid;
    logic [7:0] cpu_rsp_rdata;

    logic       ext_req;
    logic       ext_we;
    addr_t      ext_addr;
    logic [7:0] ext_wdata;
    logic       ext_ack;
    logic [7:0] ext_rdata;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata
    );

endinterface

// File: rtl/sm83_hram.sv
// 127x8 high RAM. Synchronous write; read data is registered so it lines up
// with the LOCAL response cycle. Contents are deliberately not reset.
module sm83_hram
    import sm83_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [HRAM_AW-1:0] addr_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o
);

    logic [7:0] mem_q [HRAM_DEPTH];
    logic [7:0] rdata_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read port, loaded on the accept edge of a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sm83_bus_resp.sv
// SM83 bus responder: serves HRAM, IF and IE locally in one cycle, blocks the
// unusable OAM tail, and forwards everything else to the external port with a
// bounded wait.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request (cpu_req_ready high)
// LOCAL    | local access response cycle (rsp_valid high)
// EXT_WAIT | ext_req held, waiting for ext_ack or the wait budget to run out
// RESP     | external access response cycle (rsp_valid high)
module sm83_bus_resp
    import sm83_pkg::*;
#(
    parameter int EXT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    sm83_bus_resp_if.slave   bus,
    input  logic [IRQ_W-1:0] irq_in,
    input  logic [IRQ_W-1:0] irq_clr,
    output logic [IRQ_W-1:0] if_o,
    output logic [7:0]       ie_o
);

    localparam int WAIT_W = (EXT_TIMEOUT < 2) ? 1 : $clog2(EXT_TIMEOUT + 1);
    // Down-counter starts at EXT_TIMEOUT-1 so terminal count lands on the
    // EXT_TIMEOUT-th waiting cycle.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EXT_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = '0;

    resp_state_e      state_q, state_d;
    logic             ready_q, ready_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             hram_rd_q, hram_rd_d;
    logic             ext_req_q, ext_req_d;
    logic             ext_we_q, ext_we_d;
    addr_t            ext_addr_q, ext_addr_d;
    logic [7:0]       ext_wdata_q, ext_wdata_d;
    logic [IRQ_W-1:0] if_q, if_d;
    logic [7:0]       ie_q, ie_d;

    logic             accept;
    region_e          region;
    logic             hram_we;
    logic             hram_re;
    logic [7:0]       hram_rdata;
    logic [7:0]       local_rdata;
    logic             if_wr;
    logic [IRQ_W-1:0] if_wr_mask;
    logic [IRQ_W-1:0] if_wr_bits;

    // ready_q is only ever high in IDLE, so it doubles as the accept qualifier.
    assign accept  = bus.cpu_req_valid & ready_q;
    assign region  = decode_addr(bus.cpu_req_addr);
    assign hram_we = accept &  bus.cpu_req_we & (region == RGN_HRAM);
    assign hram_re = accept & ~bus.cpu_req_we & (region == RGN_HRAM);

    sm83_hram u_hram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (hram_we),
        .re_i    (hram_re),
        .addr_i  (bus.cpu_req_addr[HRAM_AW-1:0]),
        .wdata_i (bus.cpu_req_wdata),
        .rdata_o (hram_rdata)
    );

    // Read data for non-HRAM local targets, sampled at accept.
    always_comb begin
        local_rdata = OPEN_BUS;
        if (!bus.cpu_req_we) begin
            case (region)
                RGN_IF:  local_rdata = {3'b111, if_q};
                RGN_IE:  local_rdata = ie_q;
                default: local_rdata = OPEN_BUS;
            endcase
        end
    end

    // Interrupt flag / enable update; irq_in wins over clear and CPU write.
    always_comb begin
        if_wr      = accept & bus.cpu_req_we & (region == RGN_IF);
        if_wr_mask = if_wr ? {IRQ_W{1'b1}} : '0;
        if_wr_bits = if_wr ? bus.cpu_req_wdata[IRQ_W-1:0] : '0;
        if_d       = (if_q & ~irq_clr & ~if_wr_mask) | if_wr_bits | irq_in;
        ie_d       = ie_q;
        if (accept && bus.cpu_req_we && region == RGN_IE) begin
            ie_d = bus.cpu_req_wdata;
        end
    end

    // Responder next-state, external port and response data.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        rdata_d     = rdata_q;
        hram_rd_d   = hram_rd_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (region == RGN_EXT) begin
                        state_d     = EXT_WAIT;
                        wait_d      = WAIT_LOAD;
                        hram_rd_d   = 1'b0;
                        ext_req_d   = 1'b1;
                        ext_we_d    = bus.cpu_req_we;
                        ext_addr_d  = bus.cpu_req_addr;
                        ext_wdata_d = bus.cpu_req_wdata;
                    end else begin
                        state_d   = LOCAL;
                        hram_rd_d = hram_re;
                        rdata_d   = local_rdata;
                    end
                end
            end
            LOCAL: begin
                state_d = IDLE;
            end
            EXT_WAIT: begin
                if (bus.ext_ack) begin
                    state_d   = RESP;
                    wait_d    = WAIT_ZERO;
                    ext_req_d = 1'b0;
                    rdata_d   = ext_we_q ? OPEN_BUS : bus.ext_rdata;
                end else if (wait_q == WAIT_ZERO) begin
                    state_d   = RESP;
                    ext_req_d = 1'b0;
                    rdata_d   = OPEN_BUS;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            wait_q      <= WAIT_ZERO;
            rdata_q     <= 8'h00;
            hram_rd_q   <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            if_q        <= '0;
            ie_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            hram_rd_q   <= hram_rd_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            if_q        <= if_d;
            ie_q        <= ie_d;
        end
    end

    assign bus.cpu_req_ready = ready_q;
    assign bus.cpu_rsp_valid = (state_q == LOCAL) || (state_q == RESP);
    assign bus.cpu_rsp_rdata = ((state_q == LOCAL) && hram_rd_q) ? hram_rdata : rdata_q;
    assign bus.ext_req       = ext_req_q;
    assign bus.ext_we        = ext_we_q;
    assign bus.ext_addr      = ext_addr_q;
    assign bus.ext_wdata     = ext_wdata_q;
    assign if_o              = if_q;
    assign ie_o              = ie_q;

endmodule

// File: tb/tb_sm83_bus_resp.sv
// Bench for sm83_bus_resp: transaction-level reference model (address map,
// memory image, interrupt flag rules, latency per access kind) compared
// against the DUT every cycle, plus directed literal checks.
module tb_sm83_bus_resp;

    localparam int T = 4;
    localparam int R_HRAM = 0, R_IF = 1, R_IE = 2, R_UNUS = 3, R_EXT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] irq_in = 5'h00;
    logic [4:0] irq_clr = 5'h00;
    logic [4:0] if_o;
    logic [7:0] ie_o;

    sm83_bus_resp_if bus();

    sm83_bus_resp #(.EXT_TIMEOUT(T)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .irq_in  (irq_in),
        .irq_clr (irq_clr),
        .if_o    (if_o),
        .ie_o    (ie_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  hram_m [127];
    logic [4:0]  if_m = 5'h00;
    logic [7:0]  ie_m = 8'h00;
    logic        if_wr_now = 1'b0;
    logic [4:0]  if_wr_data = 5'h00;
    logic        irq_en = 1'b0;
    logic        chk_en = 1'b0;

    logic        exp_ready = 1'b0;
    logic        exp_valid = 1'b0;
    logic [7:0]  exp_rdata = 8'h00;
    logic        exp_ext_req = 1'b0;
    logic [15:0] exp_ext_addr = 16'h0000;
    logic        exp_ext_we = 1'b0;
    logic [7:0]  exp_ext_wdata = 8'h00;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region_of(input logic [15:0] a);
        if (a == 16'hFFFF) return R_IE;
        if (a == 16'hFF0F) return R_IF;
        if (a >= 16'hFF80) return R_HRAM;
        if (a >= 16'hFEA0 && a <= 16'hFEFF) return R_UNUS;
        return R_EXT;
    endfunction

    // Interrupt flag reference: per bit, a raise beats a CPU write, which beats a clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_m = 5'h00;
        end else begin
            for (int b = 0; b < 5; b++) begin
                if (irq_in[b])       if_m[b] = 1'b1;
                else if (if_wr_now)  if_m[b] = if_wr_data[b];
                else if (irq_clr[b]) if_m[b] = 1'b0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_req_ready", {15'h0, bus.cpu_req_ready}, {15'h0, exp_ready});
            chk("cpu_rsp_valid", {15'h0, bus.cpu_rsp_valid}, {15'h0, exp_valid});
            if (exp_valid) chk("cpu_rsp_rdata", {8'h0, bus.cpu_rsp_rdata}, {8'h0, exp_rdata});
            chk("if_o", {11'h0, if_o}, {11'h0, if_m});
            chk("ie_o", {8'h0, ie_o}, {8'h0, ie_m});
            chk("ext_req", {15'h0, bus.ext_req}, {15'h0, exp_ext_req});
            if (exp_ext_req) begin
                chk("ext_addr", bus.ext_addr, exp_ext_addr);
                chk("ext_we", {15'h0, bus.ext_we}, {15'h0, exp_ext_we});
                chk("ext_wdata", {8'h0, bus.ext_wdata}, {8'h0, exp_ext_wdata});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (irq_en) begin
            irq_in  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
            irq_clr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
        end else begin
            irq_in  = 5'h00;
            irq_clr = 5'h00;
        end
    endtask

    // Requests presented while busy must be ignored.
    task automatic junk();
        bus.cpu_req_valid = 1'($urandom_range(0, 1));
        bus.cpu_req_we    = 1'($urandom_range(0, 1));
        bus.cpu_req_addr  = 16'($urandom);
        bus.cpu_req_wdata = 8'($urandom);
    endtask

    task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input int ack_cyc, input logic [7:0] ext_rd, output logic [7:0] got);
        int rg;
        int idx;
        logic [7:0] exp_d;
        rg  = region_of(addr);
        idx = int'(addr) - 65408;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wd;
        if (rg != R_EXT) begin
            exp_d = 8'hFF;
            if (!we) begin
                case (rg)
                    R_HRAM:  exp_d = hram_m[idx];
                    R_IF:    exp_d = {3'b111, if_m};
                    R_IE:    exp_d = ie_m;
                    default: exp_d = 8'hFF;
                endcase
            end
            if (we && rg == R_IF) begin
                if_wr_now  = 1'b1;
                if_wr_data = wd[4:0];
            end
            step();
            if_wr_now = 1'b0;
            if (we && rg == R_HRAM) hram_m[idx] = wd;
            if (we && rg == R_IE)   ie_m = wd;
            junk();
            bus.ext_ack = 1'($urandom_range(0, 1));
            exp_ready = 1'b0;
            exp_valid = 1'b1;
            exp_rdata = exp_d;
            #3 got = bus.cpu_rsp_rdata;
            step();
        end else begin
            step();
            junk();
            exp_ready     = 1'b0;
            exp_ext_req   = 1'b1;
            exp_ext_addr  = addr;
            exp_ext_we    = we;
            exp_ext_wdata = wd;
            exp_d = 8'hFF;
            for (int c = 1; c <= T; c++) begin
                bus.ext_ack   = (c == ack_cyc);
                bus.ext_rdata = (c == ack_cyc) ? ext_rd : 8'($urandom);
                if (c == ack_cyc && !we) exp_d = ext_rd;
                step();
                junk();
                bus.ext_ack = 1'b0;
                if (c == ack_cyc) break;
            end
            exp_ext_req = 1'b0;
            exp_valid   = 1'b1;
            exp_rdata   = exp_d;
            bus.ext_ack = 1'($urandom_range(0, 1));
            #3 got = bus.cpu_rsp_rdata;
            step();
        end
        bus.cpu_req_valid = 1'b0;
        bus.ext_ack       = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] edges [6];
        edges[0] = 16'hFF7F; edges[1] = 16'hFE9F; edges[2] = 16'hFF00;
        edges[3] = 16'hFF10; edges[4] = 16'hFF0E; edges[5] = 16'hFF00;
        case ($urandom_range(0, 9))
            0, 1, 2: return 16'hFF80 + 16'($urandom_range(0, 126));
            3:       return 16'hFF0F;
            4:       return 16'hFFFF;
            5:       return 16'hFEA0 + 16'($urandom_range(0, 95));
            6:       return edges[$urandom_range(0, 5)];
            default: return 16'($urandom);
        endcase
    endfunction

    logic [7:0] got;

    initial begin
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = 16'h0000;
        bus.cpu_req_wdata = 8'h00;
        bus.ext_ack       = 1'b0;
        bus.ext_rdata     = 8'h00;
        for (int i = 0; i < 127; i++) hram_m[i] = 8'h00;

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        exp_ready = 1'b1;

        // Directed scenarios with interrupts quiet.
        access(1'b1, 16'hFF80, 8'h5A, 0, 8'h00, got);
        access(1'b0, 16'hFF80, 8'h00, 0, 8'h00, got);
        chk("hram_read_5a", {8'h0, got}, 16'h005A);

        access(1'b1, 16'hFF0F, 8'h1F, 0, 8'h00, got);
        chk("if_after_write_1f", {11'h0, if_o}, 16'h001F);
        access(1'b0, 16'hFF0F, 8'h00, 0, 8'h00, got);
        chk("if_read_ff", {8'h0, got}, 16'h00FF);
        irq_in = 5'b00100;
        access(1'b1, 16'hFF0F, 8'h00, 0, 8'h00, got);
        chk("if_irq_beats_write", {11'h0, if_o}, 16'h0004);

        access(1'b0, 16'h8000, 8'h00, 4, 8'hC3, got);
        chk("ext_read_c3", {8'h0, got}, 16'h00C3);

        access(1'b0, 16'h4000, 8'h00, 0, 8'h00, got);
        chk("ext_timeout_ff", {8'h0, got}, 16'h00FF);
        #3 chk("ready_after_timeout", {15'h0, bus.cpu_req_ready}, 16'h0001);

        access(1'b0, 16'hFEA5, 8'h00, 0, 8'h00, got);
        chk("unusable_read_ff", {8'h0, got}, 16'h00FF);
        access(1'b1, 16'hFFFF, 8'h1F, 0, 8'h00, got);
        chk("ie_after_write", {8'h0, ie_o}, 16'h001F);

        access(1'b0, 16'hFF7F, 8'h00, 1, 8'h11, got);
        chk("ff7f_is_external", {8'h0, got}, 16'h0011);
        access(1'b1, 16'hFFFE, 8'hA7, 0, 8'h00, got);
        access(1'b0, 16'hFFFE, 8'h00, 0, 8'h00, got);
        chk("hram_top_a7", {8'h0, got}, 16'h00A7);
        access(1'b1, 16'h9000, 8'h3C, 2, 8'h77, got);
        chk("ext_write_rdata_ff", {8'h0, got}, 16'h00FF);

        // Fill HRAM, then randomized traffic with live interrupts.
        irq_en = 1'b1;
        for (int i = 0; i < 127; i++) begin
            access(1'b1, 16'hFF80 + 16'(i), 8'($urandom), 0, 8'h00, got);
        end
        for (int n = 0; n < 300; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.ext_ack = 1'($urandom_range(0, 1));
                step();
            end
            bus.ext_ack = 1'b0;
            access(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom),
                   $urandom_range(0, 6), 8'($urandom), got);
        end

        // Reset in the middle of an external wait, then a stale ack.
        irq_en = 1'b0;
        step();
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = 16'h9000;
        bus.cpu_req_wdata = 8'h00;
        step();
        bus.cpu_req_valid = 1'b0;
        exp_ready     = 1'b0;
        exp_ext_req   = 1'b1;
        exp_ext_addr  = 16'h9000;
        exp_ext_we    = 1'b0;
        exp_ext_wdata = 8'h00;
        step();
        #2 rst_n = 1'b0;
        ie_m        = 8'h00;
        exp_ext_req = 1'b0;
        exp_valid   = 1'b0;
        #1;
        chk("rst_ready", {15'h0, bus.cpu_req_ready}, 16'h0000);
        chk("rst_rsp_valid", {15'h0, bus.cpu_rsp_valid}, 16'h0000);
        chk("rst_rsp_rdata", {8'h0, bus.cpu_rsp_rdata}, 16'h0000);
        chk("rst_ext_req", {15'h0, bus.ext_req}, 16'h0000);
        chk("rst_ext_addr", bus.ext_addr, 16'h0000);
        chk("rst_ext_we", {15'h0, bus.ext_we}, 16'h0000);
        chk("rst_ext_wdata", {8'h0, bus.ext_wdata}, 16'h0000);
        chk("rst_if", {11'h0, if_o}, 16'h0000);
        chk("rst_ie", {8'h0, ie_o}, 16'h0000);
        step();
        step();
        rst_n = 1'b1;
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 8'h5C;
        step();
        exp_ready = 1'b1;
        step();
        bus.ext_ack = 1'b0;
        step();
        chk("stale_ack_rdata", {8'h0, bus.cpu_rsp_rdata}, 16'h0000);
        chk("stale_ack_ext_addr", bus.ext_addr, 16'h0000);

        // HRAM survives reset.
        access(1'b0, 16'hFF80, 8'h00, 0, 8'h00, got);
        access(1'b0, 16'hFFFE, 8'h00, 0, 8'h00, got);
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm83_bus_resp.md
SM83_BUS_RESP -- requirements
Module: sm83_bus_resp

Interface
REQ-001 Parameter EXT_TIMEOUT, default 255; maximum cycles ext_req is held waiting for ext_ack before the access is abandoned.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cpu_req_valid  in  1  CPU access request.
REQ-005 cpu_req_ready  out  1  responder can accept a request.
REQ-006 cpu_req_we  in  1  1 = write, 0 = read.
REQ-007 cpu_req_addr  in  16  byte address (package addr_t).
REQ-008 cpu_req_wdata  in  8  write data.
REQ-009 cpu_rsp_valid  out  1  single-cycle response strobe.
REQ-010 cpu_rsp_rdata  out  8  read data, valid with cpu_rsp_valid.
REQ-011 irq_in  in  5  interrupt set pulses (VBlank, STAT, Timer, Serial, Joypad = bits 0..4).
REQ-012 irq_clr  in  5  CPU-dispatch clear of IF bits.
REQ-013 if_o / ie_o  out  5 / 8  current IF and IE contents.
REQ-014 ext_req, ext_we, ext_addr[15:0], ext_wdata[7:0]  out  external access port.
REQ-015 ext_ack  in  1; ext_rdata  in  8  external completion and read data.

Function
REQ-016 Handshake: request accepted on the cycle where cpu_req_valid && cpu_req_ready; cpu_req_ready is high only in IDLE.
REQ-017 FSM states IDLE, LOCAL, EXT_WAIT, RESP; IDLE->LOCAL on accept of a local address, IDLE->EXT_WAIT on accept of any other address, LOCAL->IDLE, EXT_WAIT->RESP on ext_ack or timeout, RESP->IDLE.
REQ-018 Local decode: 0xFF80-0xFFFE HRAM (127x8), 0xFF0F IF, 0xFFFF IE, 0xFEA0-0xFEFF unusable; all other addresses external.
REQ-019 Local access latency: cpu_rsp_valid high exactly one cycle, the cycle after accept (LOCAL state).
REQ-020 Local reads: HRAM byte; IF returns {3'b111, IF[4:0]}; IE returns 8-bit IE; unusable region returns 0xFF.
REQ-021 Local writes update HRAM/IF[4:0]/IE on the accept edge; writes to unusable region ignored; write responses drive cpu_rsp_rdata = 0xFF.
REQ-022 External: ext_req and ext_addr/ext_we/ext_wdata asserted from the cycle after accept, held stable until ext_ack sampled high; ext_req deasserts the cycle after ack.
REQ-023 External response: cpu_rsp_valid in RESP, one cycle after ext_ack; read data = ext_rdata captured on ack, write rdata = 0xFF.
REQ-024 Timeout: a wait counter counts cycles in EXT_WAIT; after EXT_TIMEOUT cycles without ack, go to RESP with rdata 0xFF; ext_ack arriving on the timeout cycle counts as ack.
REQ-025 IF update each cycle: next = (IF & ~irq_clr & ~cpu_write_mask) | cpu_write_data | irq_in; irq_in set has priority over both irq_clr and a simultaneous CPU write clearing the same bit.
REQ-026 ext_ack while not in EXT_WAIT is ignored.
REQ-027 No backpressure on responses; cpu_req_valid during non-IDLE states is not accepted and has no effect.

Reset
REQ-028 rst_n low asynchronously forces IDLE, cpu_req_ready=0 while low then 1 after release, cpu_rsp_valid=0, cpu_rsp_rdata=0x00, ext_req=0, ext_addr=0x0000, ext_we=0, ext_wdata=0x00, IF=5'h00, IE=8'h00, wait counter=0.
REQ-029 HRAM contents are not reset.
REQ-030 Reset during EXT_WAIT abandons the access with no response; a later stale ext_ack is ignored.

Structure
REQ-031 Responder FSM state enum, local address constants (HRAM_BASE, HRAM_TOP, IF_ADDR, IE_ADDR, UNUSABLE_BASE/TOP) and the interrupt-bit enum belong in sm83_pkg.
REQ-032 HRAM is one sub-module, sm83_hram: 127x8, synchronous write, read registered for LOCAL response.

Verification
REQ-033 Write 0x5A to 0xFF80, then read 0xFF80 -> each rsp_valid one cycle after accept, read rdata 0x5A.
REQ-034 Write 0x1F to 0xFF0F, read 0xFF0F -> rdata 0xFF; then write 0x00 with irq_in=5'b00100 same cycle -> IF = 5'b00100.
REQ-035 Read 0x8000, ext_ack 3 cycles after ext_req with ext_rdata 0xC3 -> rsp_valid one cycle after ack, rdata 0xC3, ext_req low after ack.
REQ-036 EXT_TIMEOUT=4, read 0x4000, no ack -> rsp_valid with rdata 0xFF after timeout, FSM back to IDLE.
REQ-037 Read 0xFEA5 -> rdata 0xFF, no ext_req; write 0xFFFF=0x1F -> ie_o=0x1F.
REQ-038 Assert rst_n low mid EXT_WAIT, then ext_ack -> no rsp_valid, all outputs at reset values.
